// File: rtl/microbio_gen_pkg.sv
// microbio_gen_pkg: opcode and FSM state encodings plus the default wait-tick length.
package microbio_gen_pkg;
    localparam int T_200MS = 2400000;
    typedef enum logic [2:0] {
        OP_WAIT = 3'd0,
        OP_HALT = 3'd1,
        OP_LEDS = 3'd2,
        OP_JP   = 3'd3,
        OP_LDC  = 3'd4,
        OP_DJNZ = 3'd5,
        OP_CALL = 3'd6,
        OP_RET  = 3'd7
    } op_t;
    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;
endpackage

// File: rtl/microbio_gen_timer.sv
// microbio_gen_timer: free-running divider emitting a 1-cycle tick every WAIT_DELAY cycles after restart.
module microbio_gen_timer
    import microbio_gen_pkg::*;
#(
    parameter int WAIT_DELAY = T_200MS
) (
    input  logic clk,
    input  logic rstn,
    input  logic restart,
    output logic tick
);
    localparam int CW = $clog2(WAIT_DELAY + 1);
    localparam logic [CW-1:0] LAST = CW'(WAIT_DELAY - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    assign tick  = cnt_q == LAST;
    assign cnt_d = (restart || tick) ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/microbio_gen.sv
// microbio_gen: parametrised mini processor with WAIT, DJNZ loop counter, one-level CALL/RET and resumable HALT.
module microbio_gen
    import microbio_gen_pkg::*;
#(
    parameter int AW         = 6,
    parameter int LW         = 4,
    parameter int WAIT_DELAY = T_200MS
) (
    input  logic          clk,
    input  logic          rstn,
    output logic [AW-1:0] rom_addr,
    input  logic [AW+2:0] rom_data,
    input  logic          resume,
    output logic [LW-1:0] leds,
    output logic          stop
);
    localparam int IW = AW + 3;
    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d, cnt_q, cnt_d, link_q, link_d, tcnt_q, tcnt_d;
    logic [IW-1:0] ri_q, ri_d;
    logic [LW-1:0] leds_q, leds_d;
    logic          link_v_q, link_v_d, stop_q, restart, tick;
    op_t           op;
    logic [AW-1:0] dat, cnt_dec, tcnt_inc;

    assign op       = op_t'(ri_q[IW-1:AW]);
    assign dat      = ri_q[AW-1:0];
    assign cnt_dec  = cnt_q - 1'b1;
    assign tcnt_inc = tcnt_q + 1'b1;
    // Timer phase is aligned to the first EXEC cycle of each WAIT.
    assign restart  = state_q == ST_FETCH && op_t'(rom_data[IW-1:AW]) == OP_WAIT;

    microbio_gen_timer #(.WAIT_DELAY(WAIT_DELAY)) u_timer (
        .clk(clk), .rstn(rstn), .restart(restart), .tick(tick)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ri_d     = ri_q;
        cnt_d    = cnt_q;
        link_d   = link_q;
        link_v_d = link_v_q;
        leds_d   = leds_q;
        tcnt_d   = tcnt_q;
        case (state_q)
            ST_INIT: state_d = ST_FETCH;
            ST_FETCH: begin
                ri_d    = rom_data;
                pc_d    = pc_q + 1'b1;
                tcnt_d  = '0;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                case (op)
                    OP_WAIT: begin
                        tcnt_d  = tick ? tcnt_inc : tcnt_q;
                        state_d = (dat != '0 && !(tick && tcnt_inc == dat)) ? ST_EXEC : ST_FETCH;
                    end
                    OP_HALT: state_d = ST_HALT;
                    OP_LEDS: leds_d = dat[LW-1:0];
                    OP_JP: begin
                        pc_d    = dat;
                        state_d = ST_INIT;
                    end
                    OP_LDC: cnt_d = dat;
                    OP_DJNZ: begin
                        cnt_d   = cnt_dec;
                        pc_d    = cnt_dec != '0 ? dat : pc_q;
                        state_d = cnt_dec != '0 ? ST_INIT : ST_FETCH;
                    end
                    OP_CALL: begin
                        link_d   = pc_q;
                        link_v_d = 1'b1;
                        pc_d     = dat;
                        state_d  = ST_INIT;
                    end
                    OP_RET: begin
                        pc_d     = link_v_q ? link_q : pc_q;
                        link_v_d = 1'b0;
                        state_d  = link_v_q ? ST_INIT : ST_FETCH;
                    end
                    default: state_d = ST_FETCH;
                endcase
            end
            ST_HALT: state_d = resume ? ST_FETCH : ST_HALT;
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_INIT;
            pc_q     <= '0;
            ri_q     <= '0;
            cnt_q    <= '0;
            link_q   <= '0;
            link_v_q <= 1'b0;
            leds_q   <= '0;
            tcnt_q   <= '0;
            stop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ri_q     <= ri_d;
            cnt_q    <= cnt_d;
            link_q   <= link_d;
            link_v_q <= link_v_d;
            leds_q   <= leds_d;
            tcnt_q   <= tcnt_d;
            stop_q   <= state_d == ST_HALT;
        end
    end

    assign rom_addr = pc_q;
    assign leds     = leds_q;
    assign stop     = stop_q;
endmodule

// File: tb/tb_microbio_gen.sv
// tb_microbio_gen: instruction-level reference interpreter builds a per-cycle expected trace,
// checked against the core every cycle for directed and random programs.
module tb_microbio_gen;
    localparam int AW   = 6;
    localparam int LW   = 4;
    localparam int WD   = 4;
    localparam int MAXC = 1024;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [AW+2:0] rom_data;
    logic          resume = 1'b0;
    logic [LW-1:0] leds;
    logic          stop;

    logic [AW+2:0] rom [64];
    bit            sched [MAXC];
    int            exp_addr [MAXC], exp_leds [MAXC], exp_stop [MAXC];
    int            rec_addr [MAXC], rec_leds [MAXC], rec_stop [MAXC];
    int            n_tests = 0, n_fail = 0;

    microbio_gen #(.AW(AW), .LW(LW), .WAIT_DELAY(WD)) dut (
        .clk(clk), .rstn(rstn), .rom_addr(rom_addr), .rom_data(rom_data),
        .resume(resume), .leds(leds), .stop(stop)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= rom[rom_addr];

    function automatic logic [AW+2:0] ins(input int op, input int d);
        logic [2:0] o;
        logic [AW-1:0] v;
        o = op[2:0];
        v = d[AW-1:0];
        return {o, v};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) rom[i] = '0;
        for (int i = 0; i < MAXC; i++) sched[i] = 1'b0;
    endtask

    task automatic emit(input int reps, input int pc, input int l, input int s, inout int t);
        for (int i = 0; i < reps; i++) begin
            if (t < MAXC) begin
                exp_addr[t] = pc;
                exp_leds[t] = l;
                exp_stop[t] = s;
            end
            t++;
        end
    endtask

    // Reference: interpret instructions, emitting the visible outputs for every cycle each one takes.
    task automatic build_trace(input int n);
        int t, pc, lv, cnt, link, op, dat, jump;
        t = 0; pc = 0; lv = 0; cnt = 0; link = 0;
        begin
            int l;
            l = 0;
            emit(1, pc, l, 0, t);
            while (t < n) begin
                op  = int'(rom[pc][AW+2:AW]);
                dat = int'(rom[pc][AW-1:0]);
                emit(1, pc, l, 0, t);
                pc   = (pc + 1) % 64;
                jump = 0;
                emit(1, pc, l, 0, t);
                case (op)
                    0: emit(dat == 0 ? 0 : dat * WD - 1, pc, l, 0, t);
                    1: begin
                        do emit(1, pc, l, 1, t); while (t < n && !sched[t-1]);
                    end
                    2: l = dat % (1 << LW);
                    3: begin pc = dat; jump = 1; end
                    4: cnt = dat;
                    5: begin
                        cnt = (cnt + 63) % 64;
                        if (cnt != 0) begin pc = dat; jump = 1; end
                    end
                    6: begin link = pc; lv = 1; pc = dat; jump = 1; end
                    default: if (lv != 0) begin pc = link; lv = 0; jump = 1; end
                endcase
                if (jump != 0) emit(1, pc, l, 0, t);
            end
        end
    endtask

    task automatic run_test(input string tag, input int ncyc);
        build_trace(ncyc);
        @(negedge clk);
        rstn   = 1'b0;
        resume = 1'b0;
        #1;
        chk({tag, " reset addr"}, int'(rom_addr), 0);
        chk({tag, " reset leds/stop"}, int'({leds, stop}), 0);
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < ncyc; k++) begin
            rec_addr[k] = int'(rom_addr);
            rec_leds[k] = int'(leds);
            rec_stop[k] = int'(stop);
            n_tests++;
            if (rec_addr[k] !== exp_addr[k] || rec_leds[k] !== exp_leds[k] || rec_stop[k] !== exp_stop[k]) begin
                n_fail++;
                $display("FAIL %s cycle %0d addr/leds/stop: got %0d/%0d/%0d expected %0d/%0d/%0d",
                         tag, k, rec_addr[k], rec_leds[k], rec_stop[k], exp_addr[k], exp_leds[k], exp_stop[k]);
            end
            resume = sched[k];
            @(negedge clk);
        end
        resume = 1'b0;
    endtask

    initial begin
        clear_prog();
        rom[0] = ins(2, 5); rom[1] = ins(2, 10); rom[2] = ins(1, 0);
        run_test("basic", 110);
        chk("model basic leds@3", exp_leds[3], 5);
        chk("basic leds@3", rec_leds[3], 5);
        chk("basic leds@5", rec_leds[5], 10);
        chk("basic stop@6", rec_stop[6], 0);
        chk("basic stop@7", rec_stop[7], 1);
        chk("basic stop@107", rec_stop[107], 1);

        clear_prog();
        rom[0] = ins(0, 3); rom[1] = ins(2, 1); rom[2] = ins(1, 0);
        run_test("wait3", 30);
        chk("model wait3 addr@14", exp_addr[14], 1);
        chk("wait3 addr@14", rec_addr[14], 1);
        chk("wait3 addr@15", rec_addr[15], 2);
        chk("wait3 leds@15", rec_leds[15], 0);
        chk("wait3 leds@16", rec_leds[16], 1);

        clear_prog();
        rom[0] = ins(0, 0); rom[1] = ins(2, 3); rom[2] = ins(1, 0);
        run_test("wait0", 12);
        chk("wait0 addr@4", rec_addr[4], 2);
        chk("wait0 leds@5", rec_leds[5], 3);

        clear_prog();
        rom[0] = ins(4, 3); rom[1] = ins(2, 7); rom[2] = ins(5, 1); rom[3] = ins(1, 0);
        run_test("loop3", 30);
        chk("model loop3 stop@19", exp_stop[19], 1);
        chk("loop3 stop@18", rec_stop[18], 0);
        chk("loop3 stop@19", rec_stop[19], 1);
        chk("loop3 addr@19", rec_addr[19], 4);

        rom[0] = ins(4, 0);
        run_test("loop64", 340);
        chk("model loop64 stop@324", exp_stop[324], 1);
        chk("loop64 stop@323", rec_stop[323], 0);
        chk("loop64 stop@324", rec_stop[324], 1);

        clear_prog();
        rom[0] = ins(6, 4); rom[1] = ins(1, 0); rom[4] = ins(2, 9); rom[5] = ins(7, 0);
        run_test("call", 20);
        chk("model call addr@11", exp_addr[11], 2);
        chk("call addr@3", rec_addr[3], 4);
        chk("call leds@6", rec_leds[6], 9);
        chk("call stop@11", rec_stop[11], 1);
        chk("call addr@11", rec_addr[11], 2);

        clear_prog();
        rom[0] = ins(7, 0); rom[1] = ins(2, 2); rom[2] = ins(1, 0);
        run_test("ret_nolink", 12);
        chk("ret_nolink addr@3", rec_addr[3], 1);
        chk("ret_nolink leds@5", rec_leds[5], 2);

        clear_prog();
        rom[0] = ins(3, 63); rom[63] = ins(1, 0);
        sched[2] = 1'b1; sched[5] = 1'b1; sched[20] = 1'b1;
        run_test("wrap", 30);
        chk("wrap addr@6", rec_addr[6], 0);
        chk("wrap stop@7", rec_stop[7], 1);
        chk("wrap stop@20", rec_stop[20], 1);
        chk("wrap stop@21", rec_stop[21], 0);
        chk("wrap addr@21", rec_addr[21], 0);
        chk("wrap stop@26", rec_stop[26], 1);

        clear_prog();
        rom[0] = ins(2, 6); rom[1] = ins(0, 5); rom[2] = ins(1, 0);
        run_test("midwait", 10);
        chk("midwait leds@9", rec_leds[9], 6);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("async reset addr", int'(rom_addr), 0);
        chk("async reset leds", int'(leds), 0);
        chk("async reset stop", int'(stop), 0);
        run_test("restart", 40);
        chk("restart leds@3", rec_leds[3], 6);

        for (int p = 0; p < 12; p++) begin
            for (int i = 0; i < 64; i++) rom[i] = ins(int'($urandom_range(0, 7)), int'($urandom_range(0, 63)));
            for (int i = 0; i < MAXC; i++) sched[i] = $urandom_range(0, 7) == 0;
            run_test($sformatf("rand%0d", p), 700);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
